uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Output-device stage directly downstream of the CPU top level.
- Accepts bytes the CPU writes to its serial output port, buffers them in a small FIFO, and serialises each one as an 8N1 asynchronous frame on a single TX line.
- In simulation the TX line feeds the bench's serial decoder.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
FIFO_DEPTH, 8, FIFO entries; power of two, >=2
CNT_W, 4, width of the level output; must satisfy 2**CNT_W > FIFO_DEPTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
wr_en  input  1  write strobe from CPU output port, sampled on rising clk
wr_data  input  8  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH bytes
level  output  CNT_W  bytes currently in FIFO, excluding the byte being shifted
busy  output  1  serialiser not IDLE
overflow  output  1  sticky: a write was dropped
txd  output  1  serial line, idle high

Behaviour:
- Reset (reset==0, asynchronous; takes effect immediately, independent of clk):
  - txd=1, busy=0, full=0, level=0, overflow=0.
  - FIFO pointers cleared; FSM=IDLE; bit and baud counters cleared.
  - Reset mid-frame aborts the frame: txd returns high immediately and all queued bytes are discarded.
- Write:
  - On a rising edge with wr_en=1 and full=0, wr_data is pushed.
  - With full=1 the write is dropped and overflow is set to 1 at that edge, even if a pop happens the same edge.
  - overflow clears only on reset.
- Pop: the FSM pops the head entry only on the edges listed under FSM below.
  - Simultaneous push and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full is asserted when level==FIFO_DEPTH; no separate empty port.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. On an edge where the FIFO is non-empty, pop into the shift register, go to START, txd=0, baud counter=0.
  - No bypass: a byte written at edge N into an empty FIFO is popped at edge N+1. txd falls at N+1.
  - START: hold txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0. txd=shift[0].
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After bit 7's period, go to STOP with txd=1.
  - STOP: txd=1 for CLKS_PER_BIT cycles. On the final edge:
    - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Outputs are registered: txd changes only on clk edges (except reset). No glitches.
- busy=1 in START/DATA/STOP.
- level counts only queued bytes. It decrements on the pop edge.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps.
- wr_data is ignored when wr_en=0. X on wr_data while wr_en=0 must not propagate.

Test Plan:
1. CLKS_PER_BIT=4; release reset; write 0xA5 at edge N. Required response:
   - txd=0 over N+1..N+4;
   - data bits 1,0,1,0,0,1,0,1 each held 4 cycles;
   - txd=1 from N+37; busy=0 from N+41.
   - level goes 1 at N, 0 at N+1.
2. Write 0x00, 0xFF, 0x55 on consecutive edges. Required response:
   - three frames back-to-back with no idle cycle between them;
   - each frame's start bit begins exactly 40 cycles after the previous one;
   - level peaks at 2.
3. With the serialiser busy, write 9 bytes with FIFO_DEPTH=8. Required response:
   - full=1 after the 8th queued byte; 9th byte dropped; overflow=1;
   - exactly the first 8 queued bytes transmitted in order.
4. When level==FIFO_DEPTH and the STOP final edge coincides with wr_en=1, the write is dropped, overflow=1, and level becomes 7.
5. Drive reset=0 asynchronously (between clk edges) mid-DATA with 3 bytes queued. Required response:
   - txd=1, busy=0, level=0 immediately;
   - after release, txd stays 1 with no further frames.
6. Push and pop on the same edge with level=3: level stays 3, and the popped byte is the oldest entry.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serialiser. Writes are queued and shifted out LSB
// first, with frames back-to-back whenever the FIFO still holds data at STOP.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic [CNT_W-1:0] level,
    output logic             busy,
    output logic             overflow,
    output logic             txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [BW-1:0]    baud, baud_nxt;
    logic [2:0]       idx, idx_nxt;
    logic             txd_nxt;
    logic [7:0]       shift;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop, empty, bit_end;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign level   = count;
    assign busy    = (state != IDLE);
    assign push    = wr_en && !full;
    assign bit_end = (baud == BAUD_LAST);

    // Storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            baud     <= '0;
            idx      <= '0;
            txd      <= 1'b1;
            shift    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            baud  <= baud_nxt;
            idx   <= idx_nxt;
            txd   <= txd_nxt;
            if (pop) begin
                shift  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (wr_en && full) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!empty) state_nxt = START;
            START: if (bit_end) state_nxt = DATA;
            DATA:  if (bit_end && idx == 3'd7) state_nxt = STOP;
            STOP:  if (bit_end) state_nxt = empty ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    // txd is computed one cycle ahead so the line itself is a flop output.
    always_comb begin
        pop      = 1'b0;
        txd_nxt  = txd;
        baud_nxt = baud;
        idx_nxt  = idx;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                idx_nxt  = '0;
                txd_nxt  = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    txd_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    idx_nxt  = '0;
                    txd_nxt  = shift[0];
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (idx == 3'd7) begin
                        txd_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                        txd_nxt = shift[idx + 3'd1];
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_nxt = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        txd_nxt = 1'b0;
                    end else begin
                        txd_nxt = 1'b1;
                    end
                end else begin
                    baud_nxt = baud + 1'b1;
                end
            end
            default: begin
                txd_nxt  = 1'b1;
                baud_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a serial decoder checks each frame against
// a queue of expected bytes, alongside cycle-exact checks of the flags.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk, reset, wr_en;
    logic [7:0] wr_data;
    logic       full, busy, overflow, txd;
    logic [3:0] level;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int lvl_peak;
    int starts[$];
    logic [7:0] exp_q[$];

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .level(level), .busy(busy), .overflow(overflow), .txd(txd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (n < max_cyc && !(busy === 1'b0 && level === 4'd0)) begin
            if (level > lvl_peak) lvl_peak = level;
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic exp_txd(input int off, input logic [7:0] b);
        if (off < 1)       return 1'b1;
        else if (off <= 4) return 1'b0;
        else if (off <= 36) return b[(off - 5) / 4];
        else               return 1'b1;
    endfunction

    // Frame decoder: samples mid-bit, counting from the first low cycle.
    initial begin
        int dec_cnt;
        bit dec_active;
        logic [7:0] dec_byte, e;
        dec_active = 0;
        dec_cnt = 0;
        dec_byte = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                dec_active = 0;
            end else if (!dec_active) begin
                if (txd === 1'b0) begin
                    dec_active = 1;
                    dec_cnt = 0;
                    starts.push_back(cyc);
                end
            end else begin
                dec_cnt++;
                if (dec_cnt == 2) begin
                    check("start_bit", {31'd0, txd}, 32'd0);
                end else if (dec_cnt >= 6 && dec_cnt <= 34 && (dec_cnt - 6) % 4 == 0) begin
                    dec_byte[(dec_cnt - 6) / 4] = txd;
                end else if (dec_cnt == 38) begin
                    check("stop_bit", {31'd0, txd}, 32'd1);
                    check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_byte", {24'd0, dec_byte}, {24'd0, e});
                    end
                    dec_active = 0;
                end
            end
        end
    end

    initial begin
        int n0, w0, a0, d1, d2;
        reset = 1'b0;
        wr_en = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame 0xA5 with cycle-exact line and busy checks
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        n0 = cyc;
        wr_en = 1'b0; wr_data = 8'hxx;
        check("t1_level_n", {28'd0, level}, 32'd1);
        check("t1_txd_n", {31'd0, txd}, 32'd1);
        check("t1_busy_n", {31'd0, busy}, 32'd0);
        for (int off = 1; off <= 44; off++) begin
            @(negedge clk);
            check($sformatf("t1_txd_%0d", off), {31'd0, txd}, {31'd0, exp_txd(off, 8'hA5)});
            check($sformatf("t1_busy_%0d", off), {31'd0, busy}, {31'd0, off <= 40});
            if (off == 1) check("t1_level_n1", {28'd0, level}, 32'd0);
        end
        check("t1_cycle_base", cyc - n0, 32'd44);

        // Three consecutive writes, back-to-back frames
        starts.delete();
        lvl_peak = 0;
        wr_en = 1'b1; wr_data = 8'h00; exp_q.push_back(8'h00);
        @(negedge clk); wr_data = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge clk); wr_data = 8'h55; exp_q.push_back(8'h55);
        @(negedge clk); wr_en = 1'b0; wr_data = 8'hxx;
        wait_idle(400, "t2");
        check("t2_frames", starts.size(), 32'd3);
        d1 = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
        d2 = (starts.size() >= 3) ? starts[2] - starts[1] : -1;
        check("t2_gap1", d1, 32'd40);
        check("t2_gap2", d2, 32'd40);
        check("t2_level_peak", lvl_peak, 32'd2);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // Fill while busy, overflow, then a drop on the STOP pop edge
        wr_en = 1'b1; wr_data = 8'h10; exp_q.push_back(8'h10);
        @(negedge clk); w0 = cyc; wr_en = 1'b0;
        repeat (2) @(negedge clk);
        wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'h20 + 8'(i);
            if (i < 8) exp_q.push_back(wr_data);
            @(negedge clk);
            if (i == 7) begin
                check("t3_full8", {31'd0, full}, 32'd1);
                check("t3_level8", {28'd0, level}, 32'd8);
                check("t3_ovf_before", {31'd0, overflow}, 32'd0);
            end
        end
        wr_en = 1'b0; wr_data = 8'hxx;
        check("t3_ovf_after", {31'd0, overflow}, 32'd1);
        check("t3_level9", {28'd0, level}, 32'd8);
        check("t3_full9", {31'd0, full}, 32'd1);
        while (cyc < w0 + 40) @(negedge clk);
        check("t4_level_pre", {28'd0, level}, 32'd8);
        wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0; wr_data = 8'hxx;
        check("t4_level", {28'd0, level}, 32'd7);
        check("t4_full", {31'd0, full}, 32'd0);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        check("t4_busy", {31'd0, busy}, 32'd1);
        wait_idle(1000, "t3");
        check("t3_queue_empty", exp_q.size(), 32'd0);

        // Push and pop on the same edge with three queued
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'hB0 + 8'(i); exp_q.push_back(wr_data);
            @(negedge clk);
            if (i == 0) a0 = cyc;
        end
        wr_en = 1'b0; wr_data = 8'hxx;
        check("t6_level3", {28'd0, level}, 32'd3);
        while (cyc < a0 + 40) @(negedge clk);
        check("t6_level_pre", {28'd0, level}, 32'd3);
        wr_en = 1'b1; wr_data = 8'hB4; exp_q.push_back(8'hB4);
        @(negedge clk);
        wr_en = 1'b0; wr_data = 8'hxx;
        check("t6_level_pp", {28'd0, level}, 32'd3);
        wait_idle(1000, "t6");
        check("t6_queue_empty", exp_q.size(), 32'd0);
        check("t6_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Asynchronous reset in the middle of a data bit
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'hC0 + 8'(i); exp_q.push_back(wr_data);
            @(negedge clk);
            if (i == 0) a0 = cyc;
        end
        wr_en = 1'b0; wr_data = 8'hxx;
        while (cyc < a0 + 15) @(negedge clk);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        check("t5_level_pre", {28'd0, level}, 32'd3);
        #2 reset = 1'b0;
        #1;
        check("t5_txd", {31'd0, txd}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_level", {28'd0, level}, 32'd0);
        check("t5_full", {31'd0, full}, 32'd0);
        check("t5_ovf", {31'd0, overflow}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        starts.delete();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("t5_post_txd", {31'd0, txd}, 32'd1);
            check("t5_post_busy", {31'd0, busy}, 32'd0);
        end
        check("t5_no_frames", starts.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
